// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: instruction constants, opcode
// encodings and the fetch sequencer state type.
package riscv_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // True when an address lies on a 32-bit word boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack read port. The fetch unit is the master.
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit_pc_gen.sv
// Combinational next-PC generator: sequential increment or branch target,
// with a flag for a taken branch to a non-word-aligned address.
module fetch_pc_gen
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_sel,
  input  logic [31:0] alu_out,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  // Next-PC selection; the +4 wraps naturally at the top of the address space.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    misalign = 1'b0;
    if (pc_sel) begin
      pc_next  = alu_out;
      misalign = !is_word_aligned(alu_out);
    end else begin
      pc_next  = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches one word per FETCH
// entry over the imem handshake and holds it for decode during ISSUE.
module instr_fetch_unit
  import riscv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_sel,
  input  logic [31:0]                alu_out,
  input  logic                       stall,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic                       misalign_err
);

  fetch_state_t state_r;
  fetch_state_t state_next_s;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic         misalign_r;
  logic [31:0]  pc_next_s;
  logic         misalign_s;
  logic         issue_go_s;

  fetch_pc_gen u_pc_gen (
    .pc       (pc_r),
    .pc_sel   (pc_sel),
    .alu_out  (alu_out),
    .pc_next  (pc_next_s),
    .pc_plus4 (pc_plus4),
    .misalign (misalign_s)
  );

  // Leaving ISSUE only when decode is not stalling; stall beats any branch.
  assign issue_go_s = (state_r == ISSUE) && !stall;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; HALT is only left through reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:  state_next_s = FETCH;
      FETCH: begin
        if (imem.ack) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = FETCH;
        end
      end
      ISSUE: begin
        if (stall) begin
          state_next_s = ISSUE;
        end else if (misalign_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = FETCH;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = IDLE;
    endcase
  end

  // PC, instruction and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      misalign_r <= 1'b0;
    end else begin
      if ((state_r == FETCH) && imem.ack) begin
        instr_r <= imem.rdata;
      end else if (issue_go_s) begin
        instr_r <= NOP_INSTR;
        if (misalign_s) begin
          misalign_r <= 1'b1;
        end else begin
          pc_r <= pc_next_s;
        end
      end
    end
  end

  // Handshake flags are pure state decodes so they drop at once on reset.
  assign imem.req     = (state_r == FETCH);
  assign imem.addr    = pc_r;
  assign instr_valid  = (state_r == ISSUE);
  assign instr        = instr_r;
  assign pc           = pc_r;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a
// cycle-level behavioural model of the fetch rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_sel;
  logic [31:0] alu_out;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_sel       (pc_sel),
    .alu_out      (alu_out),
    .stall        (stall),
    .imem         (imem_bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: 0 = idle after reset, 1 = waiting on memory, 2 = holding word, 3 = halted.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'h0000_0000;
    m_instr = NOP;
    m_err   = 1'b0;
  endtask

  // Apply the fetch rules for one clock edge, using the inputs held at that edge.
  task automatic model_step();
    case (m_phase)
      0: m_phase = 1;
      1: if (imem_bus.ack) begin
           m_instr = imem_bus.rdata;
           m_phase = 2;
         end
      2: if (!stall) begin
           m_instr = NOP;
           if (pc_sel && (alu_out[1:0] != 2'b00)) begin
             m_err   = 1'b1;
             m_phase = 3;
           end else begin
             m_pc    = pc_sel ? alu_out : m_pc + 32'd4;
             m_phase = 1;
           end
         end
      default: m_phase = 3;
    endcase
  endtask

  task automatic check_outputs();
    check_val("imem_req",     {31'd0, imem_bus.req}, {31'd0, (m_phase == 1)});
    check_val("imem_addr",    imem_bus.addr, m_pc);
    check_val("pc",           pc, m_pc);
    check_val("pc_plus4",     pc_plus4, m_pc + 32'd4);
    check_val("instr",        instr, m_instr);
    check_val("instr_valid",  {31'd0, instr_valid}, {31'd0, (m_phase == 2)});
    check_val("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  // mode 0: zero-wait, no stall, sequential; 1: random aligned branches;
  // 2: like 1 but branch targets may be misaligned.
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      if (mode == 0) begin
        imem_bus.ack = 1'b1;
        stall        = 1'b0;
        pc_sel       = 1'b0;
        alu_out      = $urandom;
      end else begin
        imem_bus.ack = ($urandom_range(0, 2) != 0);
        stall        = ($urandom_range(0, 3) == 0);
        pc_sel       = ($urandom_range(0, 2) == 0);
        alu_out      = {$urandom_range(0, 255), 2'b00};
        if (mode == 2 && $urandom_range(0, 7) == 0) begin
          alu_out[1:0] = 2'($urandom_range(1, 3));
        end
        if ($urandom_range(0, 15) == 0) begin
          alu_out = 32'hFFFF_FFFC;
        end
      end
      imem_bus.rdata = imem_bus.ack ? mem_word(m_pc) : $urandom;
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Asynchronous reset in mid-cycle; a late ack stays high across release.
  task automatic do_reset();
    #3;
    rst          = 1'b1;
    imem_bus.ack = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    pc_sel         = 1'b0;
    alu_out        = 32'h0;
    stall          = 1'b0;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    run_cycles(12, 0);
    for (int ep = 0; ep < 12; ep++) begin
      run_cycles(60, 1);
      run_cycles(60, 2);
      run_cycles(10, 2);
      do_reset();
      run_cycles(6, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
